// File: rtl/hs32_xu.sv
// HS32 execute unit: operand read, shift+ALU, load/store handshake, writeback, fetch redirect.
// Optional memory-ack timeout with sticky fault is compiled in with `define HS32_XU_TIMEOUT_EN.
module hs32_xu #(
    parameter int XLEN    = 32,
    parameter int NREGS   = 16,
    parameter int IMMW    = 16,
    parameter int TIMEOUT = 255,
    localparam int RA     = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req,
    output logic            rdy,
    input  logic [2:0]      aluop,
    input  logic [4:0]      shift,
    input  logic [IMMW-1:0] imm,
    input  logic [RA-1:0]   rd,
    input  logic [RA-1:0]   rm,
    input  logic [RA-1:0]   rn,
    input  logic [15:0]     ctlsig,
    output logic [XLEN-1:0] newpc,
    output logic            flush,
    output logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] dtrm,
    output logic [XLEN-1:0] dtwm,
    output logic            rw,
    output logic            reqm,
    input  logic            ackm,
    output logic [3:0]      flags,
    output logic            fault
);

    typedef enum logic [1:0] {ST_IDLE, ST_TR1, ST_TM1, ST_TW1} state_t;

    state_t          state_q, state_d;
    logic [2:0]      aluop_q, aluop_d;
    logic [4:0]      shift_q, shift_d;
    logic [IMMW-1:0] imm_q, imm_d;
    logic [RA-1:0]   rd_q, rd_d, rm_q, rm_d, rn_q, rn_d;
    logic [1:0]      dst_q, dst_d;
    logic [2:0]      src_q, src_d;
    logic            fl_q, fl_d;
    logic [XLEN-1:0] res_q, res_d, data_q, data_d;
    logic [3:0]      nzcv_q, nzcv_d, flags_q, flags_d;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    logic            is_load, is_store, is_mem, timeout_hit;
    logic [XLEN-1:0] op_a, op_b, alu_res;
    logic [XLEN:0]   sum, dif;
    logic            alu_c, alu_v;
    logic            unused_ctl;

    assign unused_ctl = ^{ctlsig[15:13], ctlsig[7:1]};
    assign is_load    = (src_q == 3'b110);
    assign is_store   = (src_q == 3'b111);
    assign is_mem     = is_load | is_store;

    // Load/store always form the address as Rm + shifted immediate.
    always_comb begin
        op_a    = regs_q[rm_q];
        op_b    = ((src_q == 3'b001 || src_q == 3'b010 || is_mem) ? XLEN'(imm_q) : regs_q[rn_q]) << shift_q;
        sum     = {1'b0, op_a} + {1'b0, op_b};
        dif     = {1'b0, op_a} - {1'b0, op_b};
        alu_res = op_a;
        alu_c   = flags_q[1];
        alu_v   = flags_q[0];
        if (is_mem) begin
            alu_res = sum[XLEN-1:0];
        end else if (src_q == 3'b001) begin
            alu_res = op_b;
        end else begin
            case (aluop_q)
                3'b000: begin
                    alu_res = sum[XLEN-1:0];
                    alu_c   = sum[XLEN];
                    alu_v   = (op_a[XLEN-1] == op_b[XLEN-1]) && (sum[XLEN-1] != op_a[XLEN-1]);
                end
                3'b001: begin
                    alu_res = dif[XLEN-1:0];
                    alu_c   = ~dif[XLEN];
                    alu_v   = (op_a[XLEN-1] != op_b[XLEN-1]) && (dif[XLEN-1] != op_a[XLEN-1]);
                end
                3'b010:  alu_res = op_a & op_b;
                3'b011:  alu_res = op_a | op_b;
                3'b100:  alu_res = op_a ^ op_b;
                3'b101:  alu_res = op_b;
                3'b110:  alu_res = op_a & ~op_b;
                default: alu_res = op_a;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req) state_d = ST_TR1;
            ST_TR1:  state_d = is_mem ? ST_TM1 : ST_TW1;
            ST_TM1: begin
                if (ackm)             state_d = is_load ? ST_TW1 : ST_IDLE;
                else if (timeout_hit) state_d = ST_IDLE;
            end
            ST_TW1:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        aluop_d = aluop_q;
        shift_d = shift_q;
        imm_d   = imm_q;
        rd_d    = rd_q;
        rm_d    = rm_q;
        rn_d    = rn_q;
        dst_d   = dst_q;
        src_d   = src_q;
        fl_d    = fl_q;
        res_d   = res_q;
        data_d  = data_q;
        nzcv_d  = nzcv_q;
        flags_d = flags_q;
        regs_d  = regs_q;
        case (state_q)
            ST_IDLE: if (req) begin
                aluop_d = aluop;
                shift_d = shift;
                imm_d   = imm;
                rd_d    = rd;
                rm_d    = rm;
                rn_d    = rn;
                dst_d   = ctlsig[12:11];
                src_d   = ctlsig[10:8];
                fl_d    = ctlsig[0];
            end
            ST_TR1: begin
                res_d  = alu_res;
                nzcv_d = {alu_res[XLEN-1], (alu_res == '0), alu_c, alu_v};
                data_d = regs_q[rd_q];
            end
            ST_TM1: if (ackm && is_load) data_d = dtrm;
            ST_TW1: begin
                if (dst_q == 2'b01) regs_d[rd_q] = is_load ? data_q : res_q;
                if (fl_q && dst_q != 2'b10) flags_d = nzcv_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            aluop_q <= '0;
            shift_q <= '0;
            imm_q   <= '0;
            rd_q    <= '0;
            rm_q    <= '0;
            rn_q    <= '0;
            dst_q   <= '0;
            src_q   <= '0;
            fl_q    <= 1'b0;
            res_q   <= '0;
            data_q  <= '0;
            nzcv_q  <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            aluop_q <= aluop_d;
            shift_q <= shift_d;
            imm_q   <= imm_d;
            rd_q    <= rd_d;
            rm_q    <= rm_d;
            rn_q    <= rn_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            fl_q    <= fl_d;
            res_q   <= res_d;
            data_q  <= data_d;
            nzcv_q  <= nzcv_d;
            flags_q <= flags_d;
        end
    end

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) regs_q[gi] <= '0;
            else        regs_q[gi] <= regs_d[gi];
        end
    end

`ifdef HS32_XU_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0] tcnt_q, tcnt_d;
    logic          fault_q, fault_d;

    // Counter idles at zero outside TM1, so every transfer starts from a clean count.
    assign timeout_hit = (state_q == ST_TM1) && !ackm && (tcnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        tcnt_d  = tcnt_q;
        fault_d = fault_q | timeout_hit;
        if (state_q != ST_TM1) tcnt_d = '0;
        else if (!ackm)        tcnt_d = tcnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            tcnt_q  <= tcnt_d;
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    assign timeout_hit = 1'b0;
    assign fault       = 1'b0;
`endif

    always_comb begin
        rdy   = (state_q == ST_IDLE);
        reqm  = (state_q == ST_TM1);
        rw    = reqm && is_store;
        addr  = reqm ? res_q : '0;
        dtwm  = rw ? data_q : '0;
        flush = (state_q == ST_TW1) && (dst_q == 2'b11);
        newpc = flush ? res_q : '0;
        flags = flags_q;
    end

endmodule

// File: tb/tb_hs32_xu.sv
// Self-checking bench for hs32_xu: scoreboard queues for memory requests and branch targets,
// register contents observed through pass-B branches.
`timescale 1ns/1ps
module tb_hs32_xu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        rdy;
    logic [2:0]  aluop = '0;
    logic [4:0]  shift = '0;
    logic [15:0] imm = '0;
    logic [3:0]  rd = '0, rm = '0, rn = '0;
    logic [15:0] ctlsig = '0;
    logic [31:0] newpc, addr, dtwm;
    logic [31:0] dtrm;
    logic        flush, rw, reqm, ackm, fault;
    logic [3:0]  flags;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] addr;
        logic        rw;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;   // -1: never acknowledge
    } mem_txn_t;

    mem_txn_t    mem_q[$];
    logic [31:0] pc_q[$];

    always #5 clk = ~clk;

    hs32_xu #(.XLEN(32), .NREGS(16), .IMMW(16), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .req(req), .rdy(rdy), .aluop(aluop), .shift(shift),
        .imm(imm), .rd(rd), .rm(rm), .rn(rn), .ctlsig(ctlsig), .newpc(newpc), .flush(flush),
        .addr(addr), .dtrm(dtrm), .dtwm(dtwm), .rw(rw), .reqm(reqm), .ackm(ackm),
        .flags(flags), .fault(fault)
    );

    // Branch-target scoreboard: every flush pops one expected newpc.
    initial begin : pc_monitor
        logic [31:0] exp_pc;
        forever begin
            @(negedge clk);
            if (flush) begin
                n_checks++;
                if (pc_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL newpc_unexpected: newpc=%h, no branch was expected", newpc);
                end else begin
                    exp_pc = pc_q.pop_front();
                    if (newpc !== exp_pc) begin
                        n_fail++;
                        $display("FAIL newpc: got %h required %h", newpc, exp_pc);
                    end else
                        $display("branch   newpc=%h ok", newpc);
                end
            end
        end
    end

    // Memory responder: checks each request against the queue and acknowledges after t.waits cycles.
    initial begin : mem_model
        mem_txn_t t;
        ackm = 1'b0;
        dtrm = '0;
        forever begin
            @(negedge clk);
            if (reqm) begin
                n_checks++;
                if (mem_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL mem_unexpected: addr=%h rw=%b with no request expected", addr, rw);
                    for (int n = 0; n < 100 && reqm; n++) @(negedge clk);
                end else begin
                    t = mem_q.pop_front();
                    if (addr !== t.addr) begin
                        n_fail++;
                        $display("FAIL mem_addr: got %h required %h", addr, t.addr);
                    end
                    n_checks++;
                    if (rw !== t.rw) begin
                        n_fail++;
                        $display("FAIL mem_rw: got %b required %b", rw, t.rw);
                    end
                    if (t.rw) begin
                        n_checks++;
                        if (dtwm !== t.wdata) begin
                            n_fail++;
                            $display("FAIL mem_dtwm: got %h required %h", dtwm, t.wdata);
                        end
                    end
                    $display("memory   addr=%h rw=%b dtwm=%h waits=%0d", addr, rw, dtwm, t.waits);
                    if (t.waits >= 0) begin
                        repeat (t.waits) @(negedge clk);
                        ackm = 1'b1;
                        dtrm = t.rdata;
                        @(negedge clk);
                        ackm = 1'b0;
                        dtrm = $urandom;
                    end else begin
                        for (int n = 0; n < 100 && reqm; n++) @(negedge clk);
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        for (int n = 0; n < 200 && !rdy; n++) @(negedge clk);
        if (!rdy) begin
            n_checks++;
            n_fail++;
            $display("FAIL rdy_wait: rdy=%b required 1 within 200 cycles", rdy);
        end
    endtask

    // Presents one instruction for a single accept cycle, then scrambles the inputs.
    task automatic issue(input logic [2:0] op, input logic [4:0] sh, input logic [15:0] im,
                         input logic [3:0] i_rd, input logic [3:0] i_rm, input logic [3:0] i_rn,
                         input logic [1:0] dd, input logic [2:0] ss, input logic ff);
        wait_idle();
        aluop  = op;
        shift  = sh;
        imm    = im;
        rd     = i_rd;
        rm     = i_rm;
        rn     = i_rn;
        ctlsig = {3'b000, dd, ss, 7'b0000000, ff};
        req    = 1'b1;
        @(negedge clk);
        req    = 1'b0;
        aluop  = 3'($urandom);
        shift  = 5'($urandom);
        imm    = 16'($urandom);
        rd     = 4'($urandom);
        rm     = 4'($urandom);
        rn     = 4'($urandom);
        ctlsig = 16'($urandom);
    endtask

    task automatic set_reg(input logic [3:0] r, input logic [31:0] v);
        issue(3'b000, 5'd16, v[31:16], r, 4'd0, 4'd0, 2'b01, 3'b001, 1'b0);
        issue(3'b011, 5'd0, v[15:0], r, r, 4'd0, 2'b01, 3'b010, 1'b0);
        wait_idle();
    endtask

    task automatic probe(input logic [3:0] r, input logic [31:0] exp_v);
        pc_q.push_back(exp_v);
        issue(3'b101, 5'd0, 16'h0, 4'd0, 4'd0, r, 2'b11, 3'b000, 1'b0);
        wait_idle();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (rdy   !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b required 1", rdy); end
        n_checks++; if (reqm  !== 1'b0) begin n_fail++; $display("FAIL reset_reqm: got %b required 0", reqm); end
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b required 0", flush); end
        n_checks++; if (flags !== 4'h0) begin n_fail++; $display("FAIL reset_flags: got %b required 0000", flags); end
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b required 0", fault); end
        n_checks++; if (addr  !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h required 0", addr); end
        $display("reset    rdy=%b reqm=%b flags=%b fault=%b", rdy, reqm, flags, fault);
        reset = 1'b1;
        @(negedge clk);
        probe(4'd5, 32'h0);
    endtask

    typedef struct packed {
        logic [2:0]  op;
        logic        f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  fl;
    } alu_vec_t;

    task automatic test_alu_ops();
        alu_vec_t v[12];
        int lat;
        v[0]  = {3'b000, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110};
        v[1]  = {3'b001, 1'b1, 32'h00000001, 32'h00000002, 32'hFFFFFFFF, 4'b1000};
        v[2]  = {3'b010, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1000};
        v[3]  = {3'b001, 1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011};
        v[4]  = {3'b011, 1'b1, 32'h0000000F, 32'h000000F0, 32'h000000FF, 4'b0011};
        v[5]  = {3'b100, 1'b1, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 4'b0111};
        v[6]  = {3'b000, 1'b1, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001};
        v[7]  = {3'b101, 1'b1, 32'h00000000, 32'h12345678, 32'h12345678, 4'b0001};
        v[8]  = {3'b110, 1'b1, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00000, 4'b1001};
        v[9]  = {3'b111, 1'b1, 32'h00000055, 32'h00000000, 32'h00000055, 4'b0001};
        v[10] = {3'b001, 1'b1, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0110};
        v[11] = {3'b000, 1'b0, 32'h00000001, 32'h00000001, 32'h00000002, 4'b0110};
        for (int i = 0; i < 12; i++) begin
            set_reg(4'd1, v[i].a);
            set_reg(4'd2, v[i].b);
            issue(v[i].op, 5'd0, 16'h0, 4'd3, 4'd1, 4'd2, 2'b01, 3'b000, v[i].f);
            lat = 1;
            while (!rdy && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            n_checks++;
            if (lat != 3) begin n_fail++; $display("FAIL alu_latency[%0d]: got %0d cycles required 3", i, lat); end
            n_checks++;
            if (flags !== v[i].fl) begin n_fail++; $display("FAIL alu_flags[%0d]: got %b required %b", i, flags, v[i].fl); end
            $display("alu[%0d]   op=%b a=%h b=%h flags=%b latency=%0d", i, v[i].op, v[i].a, v[i].b, flags, lat);
            probe(4'd3, v[i].res);
        end
    endtask

    task automatic test_imm_shift();
        set_reg(4'd1, 32'h10);
        issue(3'b000, 5'd4, 16'h0003, 4'd6, 4'd1, 4'd0, 2'b01, 3'b010, 1'b0);
        probe(4'd6, 32'h40);
        issue(3'b010, 5'd31, 16'h8001, 4'd7, 4'd0, 4'd0, 2'b01, 3'b001, 1'b0);
        probe(4'd7, 32'h80000000);
        set_reg(4'd2, 32'h3);
        issue(3'b101, 5'd2, 16'h0, 4'd8, 4'd0, 4'd2, 2'b01, 3'b000, 1'b0);
        probe(4'd8, 32'hC);
    endtask

    task automatic test_load_wait();
        set_reg(4'd4, 32'h100);
        mem_q.push_back('{32'h108, 1'b0, 32'h0, 32'hDEADBEEF, 3});
        issue(3'b000, 5'd0, 16'h0008, 4'd9, 4'd4, 4'd0, 2'b01, 3'b110, 1'b0);
        probe(4'd9, 32'hDEADBEEF);
        mem_q.push_back('{32'h120, 1'b0, 32'h0, 32'h0BADF00D, 0});
        issue(3'b000, 5'd0, 16'h0020, 4'd10, 4'd4, 4'd0, 2'b01, 3'b110, 1'b0);
        probe(4'd10, 32'h0BADF00D);
    endtask

    task automatic test_store_branch();
        int lat;
        int nf;
        set_reg(4'd5, 32'hCAFE);
        issue(3'b001, 5'd0, 16'h0001, 4'd11, 4'd0, 4'd0, 2'b01, 3'b010, 1'b1);
        wait_idle();
        n_checks++;
        if (flags !== 4'b1000) begin n_fail++; $display("FAIL pre_store_flags: got %b required 1000", flags); end
        mem_q.push_back('{32'h110, 1'b1, 32'hCAFE, 32'h0, 2});
        issue(3'b000, 5'd0, 16'h0010, 4'd5, 4'd4, 4'd0, 2'b10, 3'b111, 1'b1);
        lat = 1;
        while (!rdy && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat != 5) begin n_fail++; $display("FAIL store_latency: got %0d cycles required 5", lat); end
        n_checks++;
        if (flags !== 4'b1000) begin n_fail++; $display("FAIL store_flags: got %b required 1000", flags); end
        $display("store    latency=%0d flags=%b", lat, flags);
        pc_q.push_back(32'h200);
        issue(3'b101, 5'd0, 16'h0200, 4'd0, 4'd0, 4'd0, 2'b11, 3'b001, 1'b0);
        nf = 0;
        for (int k = 0; k < 6; k++) begin
            if (flush) nf++;
            @(negedge clk);
        end
        n_checks++;
        if (nf != 1) begin n_fail++; $display("FAIL flush_width: got %0d cycles required 1", nf); end
        $display("branch   flush cycles=%0d", nf);
    endtask

    task automatic test_reset_mid_load();
        set_reg(4'd9, 32'h200);
        set_reg(4'd8, 32'h1234);
        mem_q.push_back('{32'h204, 1'b0, 32'h0, 32'h5555AAAA, -1});
        issue(3'b000, 5'd0, 16'h0004, 4'd8, 4'd9, 4'd0, 2'b01, 3'b110, 1'b0);
        for (int n = 0; n < 20 && !reqm; n++) @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (reqm !== 1'b1) begin n_fail++; $display("FAIL midload_reqm_before: got %b required 1", reqm); end
        reset = 1'b0;
        #1;
        n_checks++; if (reqm  !== 1'b0) begin n_fail++; $display("FAIL midload_reqm: got %b required 0", reqm); end
        n_checks++; if (rdy   !== 1'b1) begin n_fail++; $display("FAIL midload_rdy: got %b required 1", rdy); end
        n_checks++; if (flags !== 4'h0) begin n_fail++; $display("FAIL midload_flags: got %b required 0000", flags); end
        $display("midreset reqm=%b rdy=%b flags=%b", reqm, rdy, flags);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        probe(4'd8, 32'h0);
    endtask

    task automatic test_back_to_back();
        issue(3'b000, 5'd0, 16'h0011, 4'd10, 4'd0, 4'd0, 2'b01, 3'b001, 1'b0);
        // Hold a second request while busy: it must be dropped, not queued.
        req    = 1'b1;
        imm    = 16'h0022;
        rd     = 4'd11;
        shift  = 5'd0;
        ctlsig = {3'b000, 2'b01, 3'b001, 7'b0000000, 1'b0};
        @(negedge clk);
        req    = 1'b0;
        wait_idle();
        issue(3'b000, 5'd0, 16'h0001, 4'd12, 4'd10, 4'd0, 2'b01, 3'b010, 1'b0);
        probe(4'd10, 32'h11);
        probe(4'd11, 32'h0);
        probe(4'd12, 32'h12);
    endtask

`ifdef HS32_XU_TIMEOUT_EN
    task automatic test_timeout();
        int nreq;
        set_reg(4'd13, 32'h55);
        mem_q.push_back('{32'h40, 1'b0, 32'h0, 32'h0, -1});
        issue(3'b000, 5'd0, 16'h0040, 4'd13, 4'd0, 4'd0, 2'b01, 3'b110, 1'b0);
        nreq = 0;
        for (int k = 0; k < 20; k++) begin
            if (reqm) nreq++;
            @(negedge clk);
        end
        n_checks++; if (nreq != 4)    begin n_fail++; $display("FAIL timeout_reqm_cycles: got %0d required 4", nreq); end
        n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL timeout_fault: got %b required 1", fault); end
        n_checks++; if (rdy !== 1'b1)   begin n_fail++; $display("FAIL timeout_rdy: got %b required 1", rdy); end
        $display("timeout  reqm cycles=%0d fault=%b rdy=%b", nreq, fault, rdy);
        probe(4'd13, 32'h55);
    endtask
`endif

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded 500000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        test_reset();
        test_alu_ops();
        test_imm_shift();
        test_load_wait();
        test_store_branch();
        test_reset_mid_load();
        test_back_to_back();
`ifdef HS32_XU_TIMEOUT_EN
        test_timeout();
`endif
        repeat (4) @(negedge clk);
        n_checks++;
        if (pc_q.size() != 0) begin n_fail++; $display("FAIL pc_queue_drain: %0d branches outstanding, required 0", pc_q.size()); end
        n_checks++;
        if (mem_q.size() != 0) begin n_fail++; $display("FAIL mem_queue_drain: %0d requests outstanding, required 0", mem_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
